cursor_overlay_renderer: RTL

Parametrised multi-cursor overlay renderer: keeps an internal WIDTH×HEIGHT overlay framebuffer holding NUM_CURSORS sprite-shaped cursors, each with its own position, colour and enable. On any cursor change it erases that cursor's old footprint and redraws all enabled cursors, so overlapping cursors stay correct. The VGA compositor reads the overlay through a registered pixel port; transparent pixels read as COLOR_NONE.

---
 rtl/cursor_overlay_renderer_pkg.sv | 17 +
 rtl/cursor_sprite_walker.sv | 62 ++++++
 rtl/cursor_overlay_renderer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_overlay_renderer_pkg.sv
// Shared definitions for the cursor overlay renderer: colour format, default sprite, FSM states.
package cursor_overlay_renderer_pkg;

  localparam int unsigned COLOR_WIDTH = 12;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = '0;

  // 8x8 arrow, one byte per row with row 0 in the low byte; bit dx of a row is column dx.
  localparam logic [63:0] CURSOR_SPRITE_MASK = 64'h180D_3F1F_0F07_0301;

  typedef enum logic [1:0] {
    StClear,
    StScan,
    StErase,
    StRedraw
  } render_state_e;

endpackage

// File: rtl/cursor_sprite_walker.sv
// Steps through every sprite offset (dx fastest) and reports the mask bit for the current offset.
module cursor_sprite_walker
  import cursor_overlay_renderer_pkg::*;
#(
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = CURSOR_SPRITE_MASK,
  localparam int unsigned DXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int unsigned DYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic           advance_i,
  output logic [DXW-1:0] dx_o,
  output logic [DYW-1:0] dy_o,
  output logic           opaque_o,
  output logic           last_o
);

  localparam int unsigned S  = SPRITE_W * SPRITE_H;
  localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;

  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;
  logic [SW-1:0]  bit_idx;

  // Next offset: start rewinds to (0,0) and wins over advance.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance_i) begin
      if (dx_q == DXW'(SPRITE_W - 1)) begin
        dx_d = '0;
        dy_d = (dy_q == DYW'(SPRITE_H - 1)) ? '0 : dy_q + DYW'(1);
      end else begin
        dx_d = dx_q + DXW'(1);
      end
    end
  end

  // Offset counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign bit_idx  = SW'(dy_q) * SW'(SPRITE_W) + SW'(dx_q);
  assign opaque_o = SPRITE_MASK[bit_idx];
  assign last_o   = (dx_q == DXW'(SPRITE_W - 1)) && (dy_q == DYW'(SPRITE_H - 1));
  assign dx_o     = dx_q;
  assign dy_o     = dy_q;

endmodule

// File: rtl/cursor_overlay_renderer.sv
// Multi-cursor overlay framebuffer: erases a changed cursor's old footprint, redraws all
// enabled cursors in index order, and serves a registered pixel read port to the compositor.
module cursor_overlay_renderer
  import cursor_overlay_renderer_pkg::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned NUM_CURSORS = 2,
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = CURSOR_SPRITE_MASK,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT),
  localparam int unsigned IW = (NUM_CURSORS > 1) ? $clog2(NUM_CURSORS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CURSORS-1:0][XW-1:0]          cursor_x,
  input  logic [NUM_CURSORS-1:0][YW-1:0]          cursor_y,
  input  logic [NUM_CURSORS-1:0][COLOR_WIDTH-1:0] cursor_color,
  input  logic [NUM_CURSORS-1:0]                   cursor_en,
  input  logic [XW-1:0]                            request_x,
  input  logic [YW-1:0]                            request_y,
  output logic [COLOR_WIDTH-1:0]                   render_color,
  output logic                                     busy,
  output logic                                     update_done
);

  localparam int unsigned FB_DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW       = $clog2(FB_DEPTH);
  localparam int unsigned DXW      = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned DYW      = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [XW:0] WIDTH_LIM  = (XW + 1)'(WIDTH);
  localparam logic [YW:0] HEIGHT_LIM = (YW + 1)'(HEIGHT);

  function automatic logic [AW-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  render_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;     // cursor visited by SCAN
  logic [IW-1:0] red_q, red_d;     // cursor being drawn by REDRAW
  logic [AW-1:0] clr_q, clr_d;
  logic [XW-1:0] erase_x_q, erase_x_d;
  logic [YW-1:0] erase_y_q, erase_y_d;
  logic          update_done_q, update_done_d;

  logic [NUM_CURSORS-1:0][XW-1:0]          drawn_x_q, drawn_x_d;
  logic [NUM_CURSORS-1:0][YW-1:0]          drawn_y_q, drawn_y_d;
  logic [NUM_CURSORS-1:0][COLOR_WIDTH-1:0] drawn_color_q, drawn_color_d;
  logic [NUM_CURSORS-1:0]                  drawn_en_q, drawn_en_d;

  logic [COLOR_WIDTH-1:0] fb_mem [FB_DEPTH];
  logic [COLOR_WIDTH-1:0] render_color_q;
  logic                   fb_we;
  logic [AW-1:0]          fb_waddr;
  logic [COLOR_WIDTH-1:0] fb_wdata;

  logic           walk_start, walk_advance, walk_opaque, walk_last;
  logic [DXW-1:0] walk_dx;
  logic [DYW-1:0] walk_dy;

  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          in_bounds;
  logic [AW-1:0] pix_addr;
  logic          changed;
  logic          cursor_done;
  logic [IW-1:0] idx_next;

  cursor_sprite_walker #(
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H),
    .SPRITE_MASK (SPRITE_MASK)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .start_i   (walk_start),
    .advance_i (walk_advance),
    .dx_o      (walk_dx),
    .dy_o      (walk_dy),
    .opaque_o  (walk_opaque),
    .last_o    (walk_last)
  );

  // Sprite origin: the old footprint while erasing, the cursor being drawn while redrawing.
  always_comb begin
    base_x = erase_x_q;
    base_y = erase_y_q;
    if (state_q == StRedraw) begin
      base_x = drawn_x_q[red_q];
      base_y = drawn_y_q[red_q];
    end
  end

  // Sums carry one extra bit so off-screen pixels clip instead of wrapping.
  assign sum_x     = {1'b0, base_x} + (XW + 1)'(walk_dx);
  assign sum_y     = {1'b0, base_y} + (YW + 1)'(walk_dy);
  assign in_bounds = (sum_x < WIDTH_LIM) && (sum_y < HEIGHT_LIM);
  assign pix_addr  = fb_addr(sum_x[XW-1:0], sum_y[YW-1:0]);
  assign idx_next  = (idx_q == IW'(NUM_CURSORS - 1)) ? '0 : idx_q + IW'(1);

  assign changed = (cursor_en[idx_q] != drawn_en_q[idx_q]) ||
                   (cursor_en[idx_q] && ((cursor_x[idx_q] != drawn_x_q[idx_q]) ||
                                         (cursor_y[idx_q] != drawn_y_q[idx_q]) ||
                                         (cursor_color[idx_q] != drawn_color_q[idx_q])));

  // Next-state, snapshot update and framebuffer write selection.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    red_d         = red_q;
    clr_d         = clr_q;
    erase_x_d     = erase_x_q;
    erase_y_d     = erase_y_q;
    update_done_d = 1'b0;
    drawn_x_d     = drawn_x_q;
    drawn_y_d     = drawn_y_q;
    drawn_color_d = drawn_color_q;
    drawn_en_d    = drawn_en_q;
    walk_start    = 1'b0;
    walk_advance  = 1'b0;
    cursor_done   = 1'b0;
    fb_we         = 1'b0;
    fb_waddr      = pix_addr;
    fb_wdata      = COLOR_NONE;

    unique case (state_q)
      StClear: begin
        fb_we    = 1'b1;
        fb_waddr = clr_q;
        if (clr_q == AW'(FB_DEPTH - 1)) begin
          clr_d   = '0;
          idx_d   = '0;
          state_d = StScan;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end

      StScan: begin
        if (changed) begin
          erase_x_d             = drawn_x_q[idx_q];
          erase_y_d             = drawn_y_q[idx_q];
          drawn_x_d[idx_q]      = cursor_x[idx_q];
          drawn_y_d[idx_q]      = cursor_y[idx_q];
          drawn_color_d[idx_q]  = cursor_color[idx_q];
          drawn_en_d[idx_q]     = cursor_en[idx_q];
          red_d                 = '0;
          walk_start            = 1'b1;
          state_d               = drawn_en_q[idx_q] ? StErase : StRedraw;
        end else begin
          idx_d = idx_next;
        end
      end

      StErase: begin
        walk_advance = 1'b1;
        fb_we        = walk_opaque && in_bounds;
        if (walk_last) begin
          walk_start = 1'b1;
          red_d      = '0;
          state_d    = StRedraw;
        end
      end

      StRedraw: begin
        // A disabled cursor still costs one cycle so the pass length stays predictable.
        if (drawn_en_q[red_q]) begin
          walk_advance = 1'b1;
          fb_we        = walk_opaque && in_bounds;
          fb_wdata     = drawn_color_q[red_q];
          cursor_done  = walk_last;
        end else begin
          cursor_done = 1'b1;
        end
        if (cursor_done) begin
          walk_start = 1'b1;
          if (red_q == IW'(NUM_CURSORS - 1)) begin
            update_done_d = 1'b1;
            idx_d         = idx_next;
            state_d       = StScan;
          end else begin
            red_d = red_q + IW'(1);
          end
        end
      end

      default: state_d = StClear;
    endcase
  end

  // Control and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClear;
      idx_q         <= '0;
      red_q         <= '0;
      clr_q         <= '0;
      erase_x_q     <= '0;
      erase_y_q     <= '0;
      update_done_q <= 1'b0;
      drawn_x_q     <= '0;
      drawn_y_q     <= '0;
      drawn_color_q <= '0;
      drawn_en_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      red_q         <= red_d;
      clr_q         <= clr_d;
      erase_x_q     <= erase_x_d;
      erase_y_q     <= erase_y_d;
      update_done_q <= update_done_d;
      drawn_x_q     <= drawn_x_d;
      drawn_y_q     <= drawn_y_d;
      drawn_color_q <= drawn_color_d;
      drawn_en_q    <= drawn_en_d;
    end
  end

  // Framebuffer write port.
  always_ff @(posedge clk) begin
    if (fb_we) begin
      fb_mem[fb_waddr] <= fb_wdata;
    end
  end

  // Registered read port; a same-cycle write to the same pixel is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      render_color_q <= COLOR_NONE;
    end else if (({1'b0, request_x} < WIDTH_LIM) && ({1'b0, request_y} < HEIGHT_LIM)) begin
      render_color_q <= fb_mem[fb_addr(request_x, request_y)];
    end else begin
      render_color_q <= COLOR_NONE;
    end
  end

  assign render_color = render_color_q;
  assign busy         = (state_q != StScan);
  assign update_done  = update_done_q;

endmodule
